dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single RAM data port (d_addr / dw_data / dw_size / d_data) between two requesters.
- Port 0 is the CPU load/store stage. Port 1 is the program loader / debug DMA.
- Accepts at most one transaction per cycle, fully pipelined. Returns read data to the owning port with fixed latency.
- Rejects misaligned writes that would break a word boundary, because the RAM cannot perform them.

Parameters:
- ADDR_W, 14, byte address width of the RAM data port.
- DATA_W, 32, data width.
- FIXED_PRIO, 0. 0 = round-robin between ports. 1 = port 0 always wins.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req0, req1  in  1  transaction request, per port
- addr0, addr1  in  ADDR_W  byte address
- wdata0, wdata1  in  DATA_W  write data, right-justified
- wsize0, wsize1  in  2  00 read, 01 byte write, 10 half write, 11 word write
- gnt0, gnt1  out  1  combinational accept; the transaction transfers at the clock edge while req&gnt
- rvalid0, rvalid1  out  1  read data valid for this port
- rdata0, rdata1  out  DATA_W  read data (valid only while rvalid)
- err0, err1  out  1  one-cycle pulse: the accepted write was misaligned and dropped
- mem_addr  out  ADDR_W  to RAM d_addr
- mem_wdata  out  DATA_W  to RAM dw_data
- mem_wsize  out  2  to RAM dw_size
- mem_rdata  in  DATA_W  from RAM d_data

Behaviour:
- Reset: mem_addr=0, mem_wdata=0, mem_wsize=00, rvalid0/1=0, err0/1=0, pipeline tags invalid, round-robin pointer favours port 0.
  - gnt0/1 are forced to 0 while resetn is low.
  - Reset mid-operation discards in-flight reads; no rvalid is issued for them after release.
- Grant, combinational within cycle T:
  - Only req0: gnt0=1.
  - Only req1: gnt1=1.
  - Both, FIXED_PRIO=1: gnt0=1.
  - Both, FIXED_PRIO=0: grant goes to the port not granted most recently.
  - Never both grants in one cycle. No grant without req.
- Round-robin pointer: updates only at an edge where a grant occurs; it then points away from the winner.
- Requester contract: hold req, addr, wdata and wsize stable until the edge where gnt=1. Dropping req before grant is allowed (request withdrawn, no side effects).
- Issue, at edge E0 ending cycle T with an accepted transaction:
  - mem_addr, mem_wdata and mem_wsize register the winner's fields.
  - Edge with no grant: mem_wsize is forced to 00; mem_addr and mem_wdata hold. A write is therefore presented to the RAM for exactly one cycle.
- Misalignment check, write only:
  - Misaligned cases: half with addr[0]=1; word with addr[1:0]!=00.
  - The transaction is still granted, but mem_wsize is registered as 00.
  - err of the winning port pulses high in cycle T+1.
  - Unaligned byte reads and half reads are passed through untouched; the RAM handles them.
- Read return:
  - The tag pipeline (valid, owner, is_read) advances every cycle: stage1 at E0, stage2 at E1.
  - In cycle T+2, rvalidX=1 iff stage2 is valid, is_read, and owner X. rdataX = mem_rdata in that cycle.
  - Fixed 2-cycle latency. Back-to-back reads give rvalid on consecutive cycles, in issue order.
  - Writes produce no rvalid.
- Read-after-write: a write accepted in cycle T followed by a read of the same word in T+1 returns the new data. The RAM commits at edge E1 before the read is sampled at E2.
- rdata0/1 are don't-care when the matching rvalid is 0; the bench must only check them under rvalid.

Test Plan:
- req0 read addr 0x0010, mem word 0x11223344 → gnt0 in T, mem_addr=0x0010 and mem_wsize=00 in T+1, rvalid0=1 and rdata0=0x11223344 in T+2, rvalid1=0 throughout.
- req0 and req1 held high 6 cycles, FIXED_PRIO=0, all reads → grants alternate 0,1,0,1,0,1 starting with port 0 after reset; rvalids alternate identically 2 cycles later. With FIXED_PRIO=1: gnt0 every cycle, gnt1 never.
- Port 1 word write 0xDEADBEEF to 0x0020 in T, port 0 read 0x0020 in T+1 → mem_wsize=11 for exactly one cycle (T+1), rvalid0 in T+3 with 0xDEADBEEF.
- Port 1 half write to 0x0003 → gnt1=1, mem_wsize stays 00, err1=1 for one cycle in T+1, memory unchanged. Port 0 byte write to 0x0003 → mem_wsize=01, no err.
- Port 0 read accepted, resetn pulled low in T+1 and released in T+3 → no rvalid0 ever for that read, mem_wsize=00, gnt0/1=0 while reset is low.
- req1 asserted then dropped before grant while port 0 is streaming → no port 1 access, no rvalid1, no err1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared RAM data port: one transaction per cycle,
// misaligned writes dropped with an error pulse, read data returned 2 cycles after grant.

module dmem_arb_port #(
  parameter int DATA_W = 32,
  parameter int PORT   = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              gnt,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        wsize,
  input  logic              tag_vld,
  input  logic              tag_own,
  input  logic              tag_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              misalign,
  output logic              err,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  // The RAM cannot split a half/word write across a word boundary.
  assign misalign = (wsize == 2'b10 && addr_lo[0]) ||
                    (wsize == 2'b11 && addr_lo != 2'b00);

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) err <= 1'b0;
    else         err <= gnt & misalign;

  assign rvalid = tag_vld & tag_rd & (tag_own == 1'(PORT));
  assign rdata  = mem_rdata;
endmodule

module dmem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [1:0]        wsize0,
  input  logic [1:0]        wsize1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_wsize,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int NUM_PORTS = 2;
  localparam int STAGES    = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        wsize;
  } req_t;

  req_t [NUM_PORTS-1:0]              rq;
  req_t                              sel;
  logic [NUM_PORTS-1:0]              req, gnt, misalign, err, rvalid;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata;
  logic                              rr_ptr, win;
  logic [STAGES:0]                   vld_pipe, own_pipe, rd_pipe;

  assign req   = {req1, req0};
  assign rq[0] = {addr0, wdata0, wsize0};
  assign rq[1] = {addr1, wdata1, wsize1};

  // rr_ptr=0 favours port 0, rr_ptr=1 favours port 1.
  always_comb begin
    gnt = '0;
    if (resetn) begin
      if (req[0] && (!req[1] || FIXED_PRIO || !rr_ptr)) gnt[0] = 1'b1;
      else if (req[1])                                 gnt[1] = 1'b1;
    end
  end

  assign win = gnt[1];
  assign sel = rq[win];

  assign vld_pipe[0] = |gnt;
  assign own_pipe[0] = win;
  assign rd_pipe[0]  = (sel.wsize == 2'b00);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr               <= 1'b0;
      vld_pipe[STAGES:1]   <= '0;
      own_pipe[STAGES:1]   <= '0;
      rd_pipe[STAGES:1]    <= '0;
      mem_addr             <= '0;
      mem_wdata            <= '0;
      mem_wsize            <= 2'b00;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      own_pipe[STAGES:1] <= own_pipe[STAGES-1:0];
      rd_pipe[STAGES:1]  <= rd_pipe[STAGES-1:0];
      if (|gnt) begin
        rr_ptr    <= ~win;
        mem_addr  <= sel.addr;
        mem_wdata <= sel.wdata;
        mem_wsize <= misalign[win] ? 2'b00 : sel.wsize;
      end else begin
        // Idle edge: deassert the write so it is presented for one cycle only.
        mem_wsize <= 2'b00;
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    dmem_arb_port #(.DATA_W(DATA_W), .PORT(p)) u_port (
      .clk       (clk),
      .resetn    (resetn),
      .gnt       (gnt[p]),
      .addr_lo   (rq[p].addr[1:0]),
      .wsize     (rq[p].wsize),
      .tag_vld   (vld_pipe[STAGES]),
      .tag_own   (own_pipe[STAGES]),
      .tag_rd    (rd_pipe[STAGES]),
      .mem_rdata (mem_rdata),
      .misalign  (misalign[p]),
      .err       (err[p]),
      .rvalid    (rvalid[p]),
      .rdata     (rdata[p])
    );
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign err0    = err[0];
  assign err1    = err[1];
  assign rvalid0 = rvalid[0];
  assign rvalid1 = rvalid[1];
  assign rdata0  = rdata[0];
  assign rdata1  = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own RAM; a transaction-level model checks both every cycle.
module tb_dmem_arbiter;
  localparam int AW = 14, DW = 32, NW = 1 << (AW - 2), NC = 1024;

  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;

  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    wsize0, wsize1;

  logic [1:0]    o_g0, o_g1, o_rv0, o_rv1, o_e0, o_e1;
  logic [DW-1:0] o_rd0 [2], o_rd1 [2], o_wd [2], m_rd [2];
  logic [AW-1:0] o_ad [2];
  logic [1:0]    o_ws [2];
  logic [DW-1:0] ram [2][NW];

  for (genvar i = 0; i < 2; i++) begin : g_dut
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(i == 1)) u_dut (
      .clk(clk), .resetn(resetn),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .wsize0(wsize0), .wsize1(wsize1),
      .gnt0(o_g0[i]), .gnt1(o_g1[i]), .rvalid0(o_rv0[i]), .rvalid1(o_rv1[i]),
      .rdata0(o_rd0[i]), .rdata1(o_rd1[i]), .err0(o_e0[i]), .err1(o_e1[i]),
      .mem_addr(o_ad[i]), .mem_wdata(o_wd[i]), .mem_wsize(o_ws[i]), .mem_rdata(m_rd[i])
    );
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [1:0] a,
                                          input logic [DW-1:0] d, input logic [1:0] sz);
    logic [DW-1:0] r;
    r = old;
    case (sz)
      2'b01: r[{a, 3'b000} +: 8]     = d[7:0];
      2'b10: r[{a[1], 4'b0000} +: 16] = d[15:0];
      2'b11: r = d;
      default: ;
    endcase
    return r;
  endfunction

  // Synchronous read-first RAM per instance.
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      m_rd[i] <= ram[i][o_ad[i][AW-1:2]];
      if (o_ws[i] != 2'b00)
        ram[i][o_ad[i][AW-1:2]] <= merge(ram[i][o_ad[i][AW-1:2]], o_ad[i][1:0], o_wd[i], o_ws[i]);
    end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: memory image plus per-cycle expected outputs scheduled from each grant.
  logic [DW-1:0] mm [2][NW];
  logic          m_rr [2];
  logic [AW-1:0] m_ad [2];
  logic [DW-1:0] m_wd [2];
  logic          s_iss [2][NC], s_e0 [2][NC], s_e1 [2][NC], s_rv0 [2][NC], s_rv1 [2][NC];
  logic [1:0]    s_ws [2][NC];
  logic [AW-1:0] s_ad [2][NC];
  logic [DW-1:0] s_wd [2][NC], s_rd [2][NC];
  logic          lg_g0 [2][NC], lg_g1 [2][NC], lg_rv0 [2][NC], lg_rv1 [2][NC];
  logic          lg_e0 [2][NC], lg_e1 [2][NC];
  logic [1:0]    lg_ws [2][NC];
  logic [AW-1:0] lg_ad [2][NC];
  logic [DW-1:0] lg_rd0 [2][NC];

  task automatic clr(input int i, input int n);
    s_iss[i][n] = 1'b0; s_e0[i][n] = 1'b0; s_e1[i][n] = 1'b0;
    s_rv0[i][n] = 1'b0; s_rv1[i][n] = 1'b0; s_ws[i][n] = 2'b00;
  endtask

  always @(negedge clk) begin : cmp
    int n, w;
    logic bad;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0] s;
    n = cyc;
    if (n + 2 < NC) begin
      for (int i = 0; i < 2; i++) begin
        lg_g0[i][n] = o_g0[i]; lg_g1[i][n] = o_g1[i]; lg_rv0[i][n] = o_rv0[i];
        lg_rv1[i][n] = o_rv1[i]; lg_e0[i][n] = o_e0[i]; lg_e1[i][n] = o_e1[i];
        lg_ws[i][n] = o_ws[i]; lg_ad[i][n] = o_ad[i]; lg_rd0[i][n] = o_rd0[i];
        if (!resetn) begin
          for (int k = 0; k < 3; k++) clr(i, n + k);
          m_ad[i] = '0; m_wd[i] = '0; m_rr[i] = 1'b0;
        end else if (s_iss[i][n]) begin
          m_ad[i] = s_ad[i][n]; m_wd[i] = s_wd[i][n];
        end
        w = -1;
        if (resetn) begin
          if (req0 && req1) w = (i == 1 || !m_rr[i]) ? 0 : 1;
          else if (req0)    w = 0;
          else if (req1)    w = 1;
        end
        chk($sformatf("u%0d c%0d gnt0", i, n), 32'(o_g0[i]), 32'(w == 0));
        chk($sformatf("u%0d c%0d gnt1", i, n), 32'(o_g1[i]), 32'(w == 1));
        chk($sformatf("u%0d c%0d mem_wsize", i, n), 32'(o_ws[i]), 32'(s_ws[i][n]));
        chk($sformatf("u%0d c%0d mem_addr", i, n), 32'(o_ad[i]), 32'(m_ad[i]));
        chk($sformatf("u%0d c%0d mem_wdata", i, n), o_wd[i], m_wd[i]);
        chk($sformatf("u%0d c%0d err0", i, n), 32'(o_e0[i]), 32'(s_e0[i][n]));
        chk($sformatf("u%0d c%0d err1", i, n), 32'(o_e1[i]), 32'(s_e1[i][n]));
        chk($sformatf("u%0d c%0d rvalid0", i, n), 32'(o_rv0[i]), 32'(s_rv0[i][n]));
        chk($sformatf("u%0d c%0d rvalid1", i, n), 32'(o_rv1[i]), 32'(s_rv1[i][n]));
        if (s_rv0[i][n]) chk($sformatf("u%0d c%0d rdata0", i, n), o_rd0[i], s_rd[i][n]);
        if (s_rv1[i][n]) chk($sformatf("u%0d c%0d rdata1", i, n), o_rd1[i], s_rd[i][n]);
        if (w >= 0) begin
          a = (w == 1) ? addr1 : addr0;
          d = (w == 1) ? wdata1 : wdata0;
          s = (w == 1) ? wsize1 : wsize0;
          m_rr[i] = (w == 0);
          bad = (s == 2'b10 && a[0]) || (s == 2'b11 && a[1:0] != 2'b00);
          s_iss[i][n+1] = 1'b1; s_ad[i][n+1] = a; s_wd[i][n+1] = d;
          s_ws[i][n+1] = bad ? 2'b00 : s;
          if (w == 0) s_e0[i][n+1] = bad; else s_e1[i][n+1] = bad;
          if (s == 2'b00) begin
            if (w == 0) s_rv0[i][n+2] = 1'b1; else s_rv1[i][n+2] = 1'b1;
            s_rd[i][n+2] = mm[i][a[AW-1:2]];
          end else if (!bad) begin
            mm[i][a[AW-1:2]] = merge(mm[i][a[AW-1:2]], a[1:0], d, s);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; wsize0 = 2'b00; wsize1 = 2'b00;
  endtask

  task automatic drv(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] s);
    if (p == 0) begin req0 = 1'b1; addr0 = a; wdata0 = d; wsize0 = s; end
    else        begin req1 = 1'b1; addr1 = a; wdata1 = d; wsize1 = s; end
  endtask

  task automatic rst_pulse();
    resetn = 1'b0; tick(); tick(); resetn = 1'b1;
  endtask

  initial begin : stim
    int t;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NW; k++) begin
        ram[i][k] <= 32'hA500_0000 ^ 32'(k);
        mm[i][k]  = 32'hA500_0000 ^ 32'(k);
      end
      ram[i][4] <= 32'h1122_3344;
      mm[i][4]  = 32'h1122_3344;
      for (int k = 0; k < NC; k++) clr(i, k);
      m_rr[i] = 1'b0; m_ad[i] = '0; m_wd[i] = '0;
    end
    idle();
    // Reset with both requests high: no grants, outputs at reset values.
    req0 = 1'b1; req1 = 1'b1; resetn = 1'b0;
    repeat (3) tick();
    chk("reset gnt0", 32'(lg_g0[0][2]), 0);
    chk("reset gnt1", 32'(lg_g1[0][2]), 0);
    chk("reset mem_wsize", 32'(lg_ws[0][2]), 0);
    chk("reset mem_addr", 32'(lg_ad[0][2]), 0);
    idle(); resetn = 1'b1; tick();

    // Simple read with 2-cycle latency.
    t = cyc; drv(0, 14'h0010, '0, 2'b00); tick(); idle(); repeat (4) tick();
    chk("rd gnt0", 32'(lg_g0[0][t]), 1);
    chk("rd mem_addr", 32'(lg_ad[0][t+1]), 32'h10);
    chk("rd mem_wsize", 32'(lg_ws[0][t+1]), 0);
    chk("rd rvalid0", 32'(lg_rv0[0][t+2]), 1);
    chk("rd rdata0", lg_rd0[0][t+2], 32'h1122_3344);
    for (int k = 0; k < 4; k++) chk($sformatf("rd rvalid1 +%0d", k), 32'(lg_rv1[0][t+k]), 0);

    // Both ports streaming reads for 6 cycles from a fresh reset.
    rst_pulse();
    t = cyc; drv(0, 14'h0100, '0, 2'b00); drv(1, 14'h0104, '0, 2'b00);
    repeat (6) tick(); idle(); repeat (3) tick();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr gnt0 +%0d", k), 32'(lg_g0[0][t+k]), 32'(k % 2 == 0));
      chk($sformatf("rr gnt1 +%0d", k), 32'(lg_g1[0][t+k]), 32'(k % 2 == 1));
      chk($sformatf("rr rvalid0 +%0d", k), 32'(lg_rv0[0][t+k+2]), 32'(k % 2 == 0));
      chk($sformatf("rr rvalid1 +%0d", k), 32'(lg_rv1[0][t+k+2]), 32'(k % 2 == 1));
      chk($sformatf("fp gnt0 +%0d", k), 32'(lg_g0[1][t+k]), 1);
      chk($sformatf("fp gnt1 +%0d", k), 32'(lg_g1[1][t+k]), 0);
    end

    // Port 1 word write, port 0 reads it back the next cycle.
    t = cyc; drv(1, 14'h0020, 32'hDEAD_BEEF, 2'b11); tick();
    idle(); drv(0, 14'h0020, '0, 2'b00); tick(); idle(); repeat (4) tick();
    chk("raw wsize T+1", 32'(lg_ws[0][t+1]), 3);
    chk("raw wsize T+2", 32'(lg_ws[0][t+2]), 0);
    chk("raw rvalid0", 32'(lg_rv0[0][t+3]), 1);
    chk("raw rdata0", lg_rd0[0][t+3], 32'hDEAD_BEEF);

    // Misaligned half write dropped; byte write at same address allowed.
    t = cyc; drv(1, 14'h0003, 32'h0000_5555, 2'b10); tick();
    idle(); drv(0, 14'h0003, 32'h0000_0077, 2'b01); tick();
    idle(); drv(0, 14'h0000, '0, 2'b00); tick(); idle(); repeat (4) tick();
    chk("mis gnt1", 32'(lg_g1[0][t]), 1);
    chk("mis wsize", 32'(lg_ws[0][t+1]), 0);
    chk("mis err1", 32'(lg_e1[0][t+1]), 1);
    chk("mis err1 clear", 32'(lg_e1[0][t+2]), 0);
    chk("byte wsize", 32'(lg_ws[0][t+2]), 1);
    chk("byte err0", 32'(lg_e0[0][t+2]), 0);
    chk("byte rdata0", lg_rd0[0][t+4], 32'h7700_0000);

    // Reset while a read is in flight.
    t = cyc; drv(0, 14'h0010, '0, 2'b00); tick();
    resetn = 1'b0; drv(1, 14'h0010, '0, 2'b00); tick(); tick();
    resetn = 1'b1; idle(); repeat (4) tick();
    for (int k = 1; k < 6; k++) chk($sformatf("mid-rst rvalid0 +%0d", k), 32'(lg_rv0[0][t+k]), 0);
    for (int k = 1; k < 3; k++) begin
      chk($sformatf("mid-rst gnt0 +%0d", k), 32'(lg_g0[0][t+k]), 0);
      chk($sformatf("mid-rst gnt1 +%0d", k), 32'(lg_g1[0][t+k]), 0);
      chk($sformatf("mid-rst wsize +%0d", k), 32'(lg_ws[0][t+k]), 0);
    end

    // Port 1 request withdrawn while port 0 streams (fixed priority instance).
    t = cyc;
    for (int k = 0; k < 6; k++) begin
      idle(); drv(0, 14'(32'h40 + 4 * k), '0, 2'b00);
      if (k == 1 || k == 2) drv(1, 14'h0080, 32'hCAFE_F00D, 2'b11);
      tick();
    end
    idle(); repeat (4) tick();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wd fp gnt1 +%0d", k), 32'(lg_g1[1][t+k]), 0);
      chk($sformatf("wd fp rvalid1 +%0d", k), 32'(lg_rv1[1][t+k]), 0);
      chk($sformatf("wd fp err1 +%0d", k), 32'(lg_e1[1][t+k]), 0);
      chk($sformatf("wd fp wsize +%0d", k), 32'(lg_ws[1][t+k]), 0);
    end

    // Aligned half write, misaligned word write, read back merged word.
    t = cyc; drv(0, 14'h0022, 32'h0000_ABCD, 2'b10); tick();
    idle(); drv(0, 14'h0041, 32'h1234_5678, 2'b11); tick();
    idle(); drv(0, 14'h0020, '0, 2'b00); tick(); idle(); repeat (4) tick();
    chk("half wsize", 32'(lg_ws[0][t+1]), 2);
    chk("word mis err0", 32'(lg_e0[0][t+2]), 1);
    chk("merge rdata0", lg_rd0[0][t+4], 32'hABCD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
